// File: rtl/prog_feeder_pkg.sv
// prog_feeder_pkg
// Shared definitions for the program feeder: opcode field position,
// opcode constants, FSM state encodings and an opcode extraction helper.
// No ports.
package prog_feeder_pkg;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_LATCH  = 3'd2;
    localparam state_t ST_ISSUE  = 3'd3;
    localparam state_t ST_IMM    = 3'd4;
    localparam state_t ST_WAIT   = 3'd5;
    localparam state_t ST_HALTED = 3'd6;

    function automatic logic [2:0] opcode_of(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/prog_feeder_watchdog.sv
// feeder_watchdog
// Done-timeout down-counter. Loads TIMEOUT_CYCLES on load, decrements
// while count_en is high, and flags expire on the last counted cycle.
// Ports:
//   clk_sys   in  clock
//   rst_b     in  asynchronous active-low reset
//   load      in  reload the counter (WAIT entry)
//   count_en  in  counting window (in WAIT)
//   expire    out high on the TIMEOUT_CYCLES-th counted cycle
module feeder_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic load,
    input  logic count_en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(TIMEOUT_CYCLES);
        end else if (count_en && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Counter holds TIMEOUT_CYCLES on the first WAIT cycle, so a value of
    // one marks the final counted cycle.
    assign expire = count_en && (cnt_q == CW'(1));

endmodule

// File: rtl/prog_feeder.sv
// prog_feeder
// Fetches instruction words from a synchronous program ROM and issues them
// to the processor: one-cycle Run strobe with the word on DIN, the mvi
// immediate on the following cycle, then waits for Done before the next
// fetch. Stops on a HALT opcode.
// Optional feature macro: FEEDER_TIMEOUT_EN (Done timeout -> Err, HALTED).
// Ports:
//   Clock, Resetn        clock / asynchronous active-low reset
//   Start                begin from PC=0 (IDLE or HALTED only)
//   Done                 processor instruction-complete pulse
//   mem_data / mem_addr  ROM read data (1-cycle latency) / address
//   DIN, Run             word to processor and instruction-valid strobe
//   Busy, Halted, Err    status
//   PC, InstrCount       current instruction address, issued count
//
// state  | meaning
// IDLE   | after reset, waiting for Start
// FETCH  | ROM address = PC
// LATCH  | capture instruction word, prefetch PC+1
// ISSUE  | instruction on DIN with Run
// IMM    | mvi immediate on DIN
// WAIT   | waiting for Done
// HALTED | HALT word seen or timeout, waiting for Start
module prog_feeder
    import prog_feeder_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Done,
    input  logic [15:0]       mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Err,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       InstrCount
);
    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic [15:0]       imm_q;
    logic [15:0]       cnt_q;
    logic              done_pend_q;
    logic              is_mvi;
    logic              wd_expire;
    logic              err_q;

    assign is_mvi = (opcode_of(ir_q) == OP_MVI);

`ifdef FEEDER_TIMEOUT_EN
    logic enter_wait;

    assign enter_wait = (state_q == ST_ISSUE && !is_mvi) || (state_q == ST_IMM);

    feeder_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_sys  (Clock),
        .rst_b    (Resetn),
        .load     (enter_wait),
        .count_en (state_q == ST_WAIT),
        .expire   (wd_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_expire      = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            imm_q       <= '0;
            cnt_q       <= '0;
            done_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (Start) begin
                        state_q <= ST_FETCH;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ST_FETCH: state_q <= ST_LATCH;
                ST_LATCH: begin
                    ir_q    <= mem_data;
                    state_q <= (opcode_of(mem_data) == OP_HALT) ? ST_HALTED : ST_ISSUE;
                end
                ST_ISSUE: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (is_mvi) begin
                        // Immediate was prefetched from PC+1 during LATCH.
                        imm_q   <= mem_data;
                        pc_q    <= pc_q + ADDR_W'(2);
                        state_q <= ST_IMM;
                    end else begin
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_IMM: begin
                    // Processor may finish mvi while the immediate is still on DIN.
                    if (Done) done_pend_q <= 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (Done || done_pend_q) begin
                        done_pend_q <= 1'b0;
                        state_q     <= ST_FETCH;
                    end else if (wd_expire) begin
                        err_q   <= 1'b1;
                        state_q <= ST_HALTED;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr = (state_q == ST_LATCH) ? pc_q + ADDR_W'(1) : pc_q;

    always_comb begin
        DIN = 16'h0000;
        case (state_q)
            ST_ISSUE: DIN = ir_q;
            ST_IMM:   DIN = imm_q;
            default:  DIN = 16'h0000;
        endcase
    end

    assign Run        = (state_q == ST_ISSUE);
    assign Busy       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign Halted     = (state_q == ST_HALTED);
    assign Err        = err_q;
    assign PC         = pc_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_prog_feeder.sv
module tb_prog_feeder;
    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic        Done;
    logic [15:0] mem_data;
    logic [1:0]  mem_addr;
    logic [15:0] DIN;
    logic        Run;
    logic        Busy;
    logic        Halted;
    logic        Err;
    logic [1:0]  PC;
    logic [15:0] InstrCount;

    logic [15:0] rom [0:3];
    int total = 0;
    int bad   = 0;

    prog_feeder #(.ADDR_W(2), .TIMEOUT_CYCLES(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Done(Done),
        .mem_data(mem_data), .mem_addr(mem_addr), .DIN(DIN), .Run(Run),
        .Busy(Busy), .Halted(Halted), .Err(Err), .PC(PC), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) mem_data <= rom[mem_addr];

    task automatic tick;
        @(negedge Clock);
    endtask

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    task automatic do_reset;
        Resetn = 1'b0; Start = 1'b0; Done = 1'b0;
        tick; tick;
        Resetn = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        load_rom(16'h0, 16'h0, 16'h0, 16'h0);
        Resetn = 1'b0; Start = 1'b0; Done = 1'b0;
        tick;
        total++; if ({mem_addr, DIN, Run, Busy, Halted, Err, PC, InstrCount} !== '0) begin bad++;
            $display("FAIL reset_outputs: got addr=%0d din=%h run=%b busy=%b halt=%b err=%b pc=%0d cnt=%0d exp all 0",
                     mem_addr, DIN, Run, Busy, Halted, Err, PC, InstrCount); end
        Resetn = 1'b1;
        tick; tick;
        total++; if (Busy !== 1'b0 || Halted !== 1'b0) begin bad++;
            $display("FAIL reset_idle: got busy=%b halted=%b exp 0 0", Busy, Halted); end
    endtask

    task automatic test_single;
        do_reset;
        load_rom(16'h0008, 16'h01C0, 16'h0, 16'h0);
        Start = 1'b1; tick; Start = 1'b0;
        total++; if (Busy !== 1'b1 || mem_addr !== 2'd0) begin bad++;
            $display("FAIL single_fetch: got busy=%b addr=%0d exp 1 0", Busy, mem_addr); end
        tick;
        total++; if (Run !== 1'b0) begin bad++; $display("FAIL single_latch_run: got %b exp 0", Run); end
        tick;
        total++; if (Run !== 1'b1 || DIN !== 16'h0008) begin bad++;
            $display("FAIL single_issue: got run=%b din=%h exp 1 0008", Run, DIN); end
        tick; Done = 1'b1;
        total++; if (Run !== 1'b0 || DIN !== 16'h0 || PC !== 2'd1 || InstrCount !== 16'd1) begin bad++;
            $display("FAIL single_wait: got run=%b din=%h pc=%0d cnt=%0d exp 0 0000 1 1", Run, DIN, PC, InstrCount); end
        tick; Done = 1'b0;
        tick; tick;
        total++; if (Halted !== 1'b1 || Busy !== 1'b0 || PC !== 2'd1 || InstrCount !== 16'd1) begin bad++;
            $display("FAIL single_halt: got halted=%b busy=%b pc=%0d cnt=%0d exp 1 0 1 1", Halted, Busy, PC, InstrCount); end
    endtask

    task automatic test_mvi;
        do_reset;
        load_rom(16'h0040, 16'h1234, 16'h01C0, 16'h0);
        Start = 1'b1; tick; Start = 1'b0;
        tick;
        total++; if (mem_addr !== 2'd1) begin bad++; $display("FAIL mvi_prefetch_addr: got %0d exp 1", mem_addr); end
        tick;
        total++; if (Run !== 1'b1 || DIN !== 16'h0040) begin bad++;
            $display("FAIL mvi_issue: got run=%b din=%h exp 1 0040", Run, DIN); end
        tick;
        total++; if (Run !== 1'b0 || DIN !== 16'h1234 || PC !== 2'd2) begin bad++;
            $display("FAIL mvi_imm: got run=%b din=%h pc=%0d exp 0 1234 2", Run, DIN, PC); end
        tick; Done = 1'b1;
        total++; if (DIN !== 16'h0) begin bad++; $display("FAIL mvi_wait_din: got %h exp 0000", DIN); end
        tick; Done = 1'b0;
        tick; tick;
        total++; if (Halted !== 1'b1 || PC !== 2'd2 || InstrCount !== 16'd1) begin bad++;
            $display("FAIL mvi_halt: got halted=%b pc=%0d cnt=%0d exp 1 2 1", Halted, PC, InstrCount); end
    endtask

    // Runs from the HALTED state left by test_mvi.
    task automatic test_done_pend;
        load_rom(16'h0040, 16'h5678, 16'h0091, 16'h01C0);
        Start = 1'b1; tick; Start = 1'b0;
        total++; if (PC !== 2'd0 || InstrCount !== 16'd0 || Halted !== 1'b0 || Busy !== 1'b1) begin bad++;
            $display("FAIL restart: got pc=%0d cnt=%0d halted=%b busy=%b exp 0 0 0 1", PC, InstrCount, Halted, Busy); end
        tick; tick;
        total++; if (Run !== 1'b1 || DIN !== 16'h0040) begin bad++;
            $display("FAIL pend_issue: got run=%b din=%h exp 1 0040", Run, DIN); end
        tick; Done = 1'b1;
        total++; if (DIN !== 16'h5678) begin bad++; $display("FAIL pend_imm: got %h exp 5678", DIN); end
        tick; Done = 1'b0;
        total++; if (Busy !== 1'b1 || Run !== 1'b0) begin bad++;
            $display("FAIL pend_wait: got busy=%b run=%b exp 1 0", Busy, Run); end
        tick;
        total++; if (mem_addr !== 2'd2) begin bad++; $display("FAIL pend_fetch_addr: got %0d exp 2", mem_addr); end
        tick; tick;
        total++; if (Run !== 1'b1 || DIN !== 16'h0091 || InstrCount !== 16'd1) begin bad++;
            $display("FAIL pend_next_issue: got run=%b din=%h cnt=%0d exp 1 0091 1", Run, DIN, InstrCount); end
        tick; tick; tick;
        Start = 1'b1; tick; Start = 1'b0;
        total++; if (PC !== 2'd3 || InstrCount !== 16'd2 || Busy !== 1'b1 || Run !== 1'b0) begin bad++;
            $display("FAIL start_ignored: got pc=%0d cnt=%0d busy=%b run=%b exp 3 2 1 0", PC, InstrCount, Busy, Run); end
        Done = 1'b1; tick; Done = 1'b0;
        tick; tick;
        total++; if (Halted !== 1'b1 || PC !== 2'd3 || InstrCount !== 16'd2) begin bad++;
            $display("FAIL pend_halt: got halted=%b pc=%0d cnt=%0d exp 1 3 2", Halted, PC, InstrCount); end
    endtask

    task automatic test_idle_done;
        do_reset;
        Done = 1'b1; tick; tick; tick; Done = 1'b0;
        tick;
        total++; if (Busy !== 1'b0 || Halted !== 1'b0 || PC !== 2'd0 || mem_addr !== 2'd0 ||
                     InstrCount !== 16'd0 || DIN !== 16'h0) begin bad++;
            $display("FAIL idle_done: got busy=%b halted=%b pc=%0d addr=%0d cnt=%0d din=%h exp all 0",
                     Busy, Halted, PC, mem_addr, InstrCount, DIN); end
    endtask

    task automatic test_wrap;
        do_reset;
        load_rom(16'h0008, 16'h0008, 16'h0008, 16'h0040);
        Start = 1'b1; tick; Start = 1'b0;
        tick; tick;
        for (int i = 0; i < 3; i++) begin
            total++; if (Run !== 1'b1 || PC !== 2'(i)) begin bad++;
                $display("FAIL wrap_issue_%0d: got run=%b pc=%0d exp 1 %0d", i, Run, PC, i); end
            tick; Done = 1'b1;
            tick; Done = 1'b0;
            tick; tick;
        end
        total++; if (Run !== 1'b1 || DIN !== 16'h0040 || PC !== 2'd3) begin bad++;
            $display("FAIL wrap_mvi_issue: got run=%b din=%h pc=%0d exp 1 0040 3", Run, DIN, PC); end
        tick;
        total++; if (Run !== 1'b0 || DIN !== 16'h0008 || PC !== 2'd1 || InstrCount !== 16'd4) begin bad++;
            $display("FAIL wrap_imm: got run=%b din=%h pc=%0d cnt=%0d exp 0 0008 1 4", Run, DIN, PC, InstrCount); end
    endtask

    task automatic test_timeout;
        do_reset;
        load_rom(16'h0008, 16'h01C0, 16'h0, 16'h0);
        Start = 1'b1; tick; Start = 1'b0;
        tick; tick;
`ifdef FEEDER_TIMEOUT_EN
        repeat (8) tick;
        total++; if (Busy !== 1'b1 || Err !== 1'b0) begin bad++;
            $display("FAIL to_wait8: got busy=%b err=%b exp 1 0", Busy, Err); end
        tick;
        total++; if (Halted !== 1'b1 || Err !== 1'b1 || PC !== 2'd1) begin bad++;
            $display("FAIL to_expire: got halted=%b err=%b pc=%0d exp 1 1 1", Halted, Err, PC); end
        Start = 1'b1; tick; Start = 1'b0;
        total++; if (Err !== 1'b0 || Busy !== 1'b1 || PC !== 2'd0) begin bad++;
            $display("FAIL to_restart: got err=%b busy=%b pc=%0d exp 0 1 0", Err, Busy, PC); end
        tick; tick;
        repeat (8) tick;
        Done = 1'b1; tick; Done = 1'b0;
        total++; if (Err !== 1'b0 || Halted !== 1'b0 || Busy !== 1'b1 || mem_addr !== 2'd1) begin bad++;
            $display("FAIL to_done_wins: got err=%b halted=%b busy=%b addr=%0d exp 0 0 1 1", Err, Halted, Busy, mem_addr); end
`else
        repeat (40) tick;
        total++; if (Busy !== 1'b1 || Err !== 1'b0 || Halted !== 1'b0) begin bad++;
            $display("FAIL no_timeout: got busy=%b err=%b halted=%b exp 1 0 0", Busy, Err, Halted); end
`endif
    endtask

    task automatic test_async_reset;
        do_reset;
        load_rom(16'h0008, 16'h01C0, 16'h0, 16'h0);
        Start = 1'b1; tick; Start = 1'b0;
        tick; tick; tick;
        total++; if (Busy !== 1'b1 || PC !== 2'd1 || InstrCount !== 16'd1) begin bad++;
            $display("FAIL ar_pre: got busy=%b pc=%0d cnt=%0d exp 1 1 1", Busy, PC, InstrCount); end
        #2 Resetn = 1'b0;
        #1;
        total++; if ({mem_addr, DIN, Run, Busy, Halted, Err, PC, InstrCount} !== '0) begin bad++;
            $display("FAIL ar_async: got addr=%0d din=%h run=%b busy=%b halt=%b err=%b pc=%0d cnt=%0d exp all 0",
                     mem_addr, DIN, Run, Busy, Halted, Err, PC, InstrCount); end
        tick; Resetn = 1'b1;
        tick;
        Start = 1'b1; tick; Start = 1'b0;
        tick;
        total++; if (Run !== 1'b0) begin bad++; $display("FAIL ar_early_run: got %b exp 0", Run); end
        tick;
        total++; if (Run !== 1'b1 || DIN !== 16'h0008 || PC !== 2'd0) begin bad++;
            $display("FAIL ar_first_run: got run=%b din=%h pc=%0d exp 1 0008 0", Run, DIN, PC); end
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; Done = 1'b0;
        test_reset;
        test_single;
        test_mvi;
        test_done_pend;
        test_idle_done;
        test_wrap;
        test_timeout;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
